// File: rtl/receptor_ps2.sv
// PS/2 keyboard receiver: synchronises and deglitches the raw PS/2 lines, frames 11-bit
// packets with odd-parity check, strips break/extended prefixes and emits make codes.
module receptor_ps2 #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter bit          DROP_BREAK  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] Dato,
  output logic       Tick,
  output logic       err_paridad,
  output logic       err_trama
);

  localparam int unsigned TcntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TcntW-1:0] TcntLast = TcntW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } state_e;

  // Two-flop synchronisers for both asynchronous PS/2 lines.
  logic clk_s1, clk_s2;
  logic dat_s1, dat_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: the filtered clock only moves once FILTER_LEN samples agree.
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_clk_q;
  logic                  filt_clk_d;
  logic                  fall;

  always_comb begin
    filt_clk_d = filt_clk_q;
    if (&filt_sr) begin
      filt_clk_d = 1'b1;
    end else if (~|filt_sr) begin
      filt_clk_d = 1'b0;
    end
  end

  assign fall = filt_clk_q & ~filt_clk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_sr    <= '1;
      filt_clk_q <= 1'b1;
    end else begin
      filt_sr    <= {filt_sr[FILTER_LEN-2:0], clk_s2};
      filt_clk_q <= filt_clk_d;
    end
  end

  // Frame assembly, validation and break filtering.
  state_e           state;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;
  logic             par;
  logic [TcntW-1:0] tcnt;
  logic             brk_pend;
  logic             frame_ok;

  assign frame_ok = dat_s2 & (^shreg ^ par);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= StIdle;
      bitcnt      <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      tcnt        <= '0;
      brk_pend    <= 1'b0;
      Dato        <= 8'h00;
      Tick        <= 1'b0;
      err_paridad <= 1'b0;
      err_trama   <= 1'b0;
    end else begin
      Tick        <= 1'b0;
      err_paridad <= 1'b0;
      err_trama   <= 1'b0;

      if (state == StIdle) begin
        tcnt <= '0;
        // A high data line on a falling edge is a spurious edge, not a start bit.
        if (fall && !dat_s2) begin
          state  <= StData;
          bitcnt <= '0;
        end
      end else if (!fall && (tcnt == TcntLast)) begin
        state     <= StIdle;
        bitcnt    <= '0;
        tcnt      <= '0;
        err_trama <= 1'b1;
      end else if (!fall) begin
        tcnt <= tcnt + TcntW'(1);
      end else begin
        tcnt <= '0;
        case (state)
          StData: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state <= StParity;
            end
          end
          StParity: begin
            par   <= dat_s2;
            state <= StStop;
          end
          StStop: begin
            state  <= StIdle;
            bitcnt <= '0;
            if (!frame_ok) begin
              err_paridad <= 1'b1;
            end else if (!DROP_BREAK) begin
              Dato <= shreg;
              Tick <= 1'b1;
            end else if (brk_pend) begin
              brk_pend <= 1'b0;
            end else if (shreg == 8'hF0) begin
              brk_pend <= 1'b1;
            end else if (shreg != 8'hE0) begin
              Dato <= shreg;
              Tick <= 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receptor_ps2.sv
// Directed bench for receptor_ps2: drives PS/2 frames bit by bit and checks emitted codes,
// error pulses, timeout recovery, glitch immunity and asynchronous reset.
module tb_receptor_ps2;

  localparam int unsigned Half    = 40;
  localparam int unsigned Timeout = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] Dato;
  logic       Tick;
  logic       err_paridad;
  logic       err_trama;

  receptor_ps2 #(
    .FILTER_LEN (8),
    .TIMEOUT_CYC(Timeout),
    .DROP_BREAK (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .Dato       (Dato),
    .Tick       (Tick),
    .err_paridad(err_paridad),
    .err_trama  (err_trama)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;
  int perr_cnt = 0;
  int terr_cnt = 0;
  int dbl_tick = 0;
  logic tick_prev = 1'b0;
  int t0, p0, e0;

  always @(negedge clk) begin
    if (Tick) tick_cnt++;
    if (err_paridad) perr_cnt++;
    if (err_trama) terr_cnt++;
    if (Tick && tick_prev) dbl_tick++;
    tick_prev = Tick;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clk(Half);
    ps2_clk = 1'b0;
    wait_clk(Half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ flip_par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    wait_clk(100);
  endtask

  task automatic snap();
    t0 = tick_cnt;
    p0 = perr_cnt;
    e0 = terr_cnt;
  endtask

  initial begin
    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clk(3);
    #1;
    check_eq("rst_dato", Dato, 8'h00);
    check_eq("rst_tick", Tick, 0);
    check_eq("rst_perr", err_paridad, 0);
    check_eq("rst_terr", err_trama, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_clk(20);

    // Single clean make code
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("t1_ticks", tick_cnt - t0, 1);
    check_eq("t1_dato", Dato, 8'h1C);
    check_eq("t1_perr", perr_cnt - p0, 0);
    check_eq("t1_terr", terr_cnt - e0, 0);

    // Make, break prefix, released key
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("t2_ticks", tick_cnt - t0, 1);
    check_eq("t2_dato", Dato, 8'h1C);
    snap();
    send_frame(8'h32, 1'b0, 1'b1);
    check_eq("t2_ticks32", tick_cnt - t0, 1);
    check_eq("t2_dato32", Dato, 8'h32);

    // Bad parity, then bad stop bit
    snap();
    send_frame(8'h1C, 1'b1, 1'b1);
    check_eq("t3_par_perr", perr_cnt - p0, 1);
    check_eq("t3_par_ticks", tick_cnt - t0, 0);
    check_eq("t3_par_dato", Dato, 8'h32);
    snap();
    send_frame(8'h1C, 1'b0, 1'b0);
    check_eq("t3_stop_perr", perr_cnt - p0, 1);
    check_eq("t3_stop_ticks", tick_cnt - t0, 0);
    check_eq("t3_stop_dato", Dato, 8'h32);

    // Truncated frame followed by a long idle clock
    snap();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_clk(Timeout + Timeout / 5);
    check_eq("t4_terr", terr_cnt - e0, 1);
    check_eq("t4_ticks", tick_cnt - t0, 0);
    check_eq("t4_perr", perr_cnt - p0, 0);
    snap();
    send_frame(8'h2B, 1'b0, 1'b1);
    check_eq("t4_ticks2b", tick_cnt - t0, 1);
    check_eq("t4_dato2b", Dato, 8'h2B);

    // Short low glitches while idle, data held low so a real edge would start a frame
    snap();
    ps2_data = 1'b0;
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      wait_clk(3);
      ps2_clk = 1'b1;
      wait_clk(30);
    end
    ps2_data = 1'b1;
    wait_clk(20);
    check_eq("t5_glitch_ticks", tick_cnt - t0, 0);
    check_eq("t5_glitch_perr", perr_cnt - p0, 0);
    check_eq("t5_glitch_terr", terr_cnt - e0, 0);
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check_eq("t5_ext_ticks", tick_cnt - t0, 1);
    check_eq("t5_ext_dato", Dato, 8'h75);

    // Reset in the middle of a frame
    ps2_bit(1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(i[0]);
    wait_clk(3);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_async_dato", Dato, 8'h00);
    check_eq("t6_async_tick", Tick, 0);
    ps2_data = 1'b1;
    wait_clk(5);
    @(negedge clk);
    rst = 1'b1;
    wait_clk(20);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("t6_ticks", tick_cnt - t0, 1);
    check_eq("t6_dato", Dato, 8'h1C);
    check_eq("t6_perr", perr_cnt - p0, 0);
    check_eq("t6_terr", terr_cnt - e0, 0);

    check_eq("tick_double", dbl_tick, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
